// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module   : sram_controller
//  Purpose  : 32-bit load/store initiator for a 16-bit asynchronous SRAM;
//             each access is two half-word cycles followed by settle cycles.
//  Revision : 1.0  initial release
// ============================================================================
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOW  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  logic [2:0]       state_q,    state_d;
  logic             op_write_q, op_write_d;
  logic [16:0]      idx_q,      idx_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic [31:0]      rdata_q,    rdata_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic        dq_drive;
  logic [15:0] dq_out;

  // State register: reset also releases the bus, since WE_N/DQ derive from state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_en || rd_en) begin
          // A simultaneous read and write request is served as a write.
          op_write_d = wr_en;
          idx_d      = 17'((address - 32'(BASE_ADDR)) >> 2);
          wdata_d    = write_data;
          state_d    = ST_LOW;
        end
      end
      ST_LOW: begin
        if (!op_write_q) rdata_d[15:0] = SRAM_DQ;
        state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (!op_write_q) rdata_d[31:16] = SRAM_DQ;
        wait_cnt_d = '0;
        state_d    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        if (wait_cnt_q == CNT_LAST) begin
          wait_cnt_d = '0;
          state_d    = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    dq_drive  = 1'b0;
    dq_out    = wdata_q[15:0];
    SRAM_ADDR = {idx_q, (state_q != ST_LOW)};
    case (state_q)
      ST_IDLE: ready = ~(wr_en | rd_en);
      ST_LOW: begin
        SRAM_WE_N = ~op_write_q;
        dq_drive  = op_write_q;
        dq_out    = wdata_q[15:0];
      end
      ST_HIGH: begin
        SRAM_WE_N = ~op_write_q;
        dq_drive  = op_write_q;
        dq_out    = wdata_q[31:16];
      end
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;
  assign read_data = rdata_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_controller
//  Purpose  : Randomised self-checking bench with an SRAM model and a
//             word-level reference memory for sram_controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_controller;

  localparam int BASE  = 1024;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         ub_n, lb_n, we_n, ce_n, oe_n;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  always #5 clk = ~clk;

  // Half-word SRAM device: drives the bus only when reading.
  logic [15:0] sram_mem [0:262143];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq;

  // Word-level reference: 32-bit words keyed by index.
  bit   [31:0] ref_mem [int];
  logic [31:0] ref_rd = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] idx_of(input logic [31:0] a);
    return 17'((a - 32'(BASE)) >> 2);
  endfunction

  // One access from its request cycle; returns the absolute cycle of the ready pulse.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input int drop_at, input bit hold,
                        output int done_abs);
    bit          is_wr;
    logic [16:0] ix;
    logic [31:0] exp_rd;
    int          done_c;
    is_wr  = wr;
    ix     = idx_of(a);
    exp_rd = is_wr ? ref_rd : (ref_mem.exists(int'(ix)) ? ref_mem[int'(ix)] : 32'h0);
    done_c = -1;
    done_abs = -1;
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    #1 check("ready_in_request_cycle", {31'b0, ready}, 32'd0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("low_addr", {14'b0, sram_addr}, {14'b0, ix, 1'b0});
        check("low_we_n", {31'b0, we_n}, {31'b0, !is_wr});
        if (is_wr) check("low_dq", {16'b0, sram_dq}, {16'b0, d[15:0]});
        address = $urandom; write_data = $urandom;
      end
      if (c == 2) begin
        check("high_addr", {14'b0, sram_addr}, {14'b0, ix, 1'b1});
        check("high_we_n", {31'b0, we_n}, {31'b0, !is_wr});
        if (is_wr) check("high_dq", {16'b0, sram_dq}, {16'b0, d[31:16]});
      end
      if (c == 3) check("read_data_in_wait", read_data, exp_rd);
      if (c == drop_at) begin wr_en = 1'b0; rd_en = 1'b0; end
      if (ready) begin done_c = c; done_abs = cyc; break; end
      if (c >= 3) check("wait_we_n", {31'b0, we_n}, 32'd1);
    end
    if (done_c < 0) check("ready_timeout", 32'd0, 32'd1);
    check("latency", 32'(done_c), 32'(3 + WAITC));
    check("read_data_done", read_data, exp_rd);
    if (is_wr) ref_mem[int'(ix)] = d;
    else ref_rd = exp_rd;
    if (!hold) begin wr_en = 1'b0; rd_en = 1'b0; end
  endtask

  initial begin
    int t1, t2;
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;

    repeat (3) @(negedge clk);
    check("reset_read_data", read_data, 32'h0);
    check("reset_we_n", {31'b0, we_n}, 32'd1);
    rst = 1'b1;
    #1 check("reset_ready_idle", {31'b0, ready}, 32'd1);

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 0, 1'b0, t1);
    access(1'b0, 1'b1, 32'd1024, 32'h0, 0, 1'b0, t1);
    access(1'b1, 1'b0, 32'd1028, 32'h12345678, 0, 1'b0, t1);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 0, 1'b0, t1);

    // Request held across two reads: pulses six cycles apart.
    access(1'b0, 1'b1, 32'd1024, 32'h0, 0, 1'b1, t1);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 0, 1'b0, t2);
    check("back_to_back_spacing", 32'(t2 - t1), 32'd6);

    access(1'b1, 1'b1, 32'd1032, 32'h0000A5A5, 0, 1'b0, t1);
    access(1'b0, 1'b1, 32'd1032, 32'h0, 0, 1'b0, t1);

    access(1'b0, 1'b1, 32'd1024, 32'h0, 2, 1'b0, t1);
    #1 check("idle_after_drop", {31'b0, ready}, 32'd1);

    // Reset during the low half of a write.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1036; write_data = 32'hCAFEF00D;
    @(negedge clk);
    check("midwrite_we_n_active", {31'b0, we_n}, 32'd0);
    rst = 1'b0;
    #1 check("midwrite_reset_we_n", {31'b0, we_n}, 32'd1);
    check("midwrite_reset_read_data", read_data, 32'h0);
    wr_en = 1'b0;
    ref_rd = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    #1 check("post_reset_ready", {31'b0, ready}, 32'd1);
    check("post_reset_read_data", read_data, 32'h0);

    for (int n = 0; n < 60; n++) begin
      bit          w, r, h;
      logic [31:0] a;
      int          op;
      op = $urandom_range(0, 4);
      w  = (op == 0) || (op == 1) || (op == 4);
      r  = (op >= 2);
      a  = ($urandom_range(0, 7) == 0) ? $urandom
                                       : 32'(BASE) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      h  = ($urandom_range(0, 3) == 0);
      access(w, r, a, $urandom, 0, h, t1);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Initiator side of the board SRAM interface. Sits between the MEM stage (32-bit byte-addressed load/store) and the 16-bit asynchronous SRAM pins.
- Each 32-bit access is split into two 16-bit SRAM cycles: low half first, then high half.
- A fixed-length access sequence runs per request. `ready` freezes the pipeline until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: idle settle cycles after the two half-word cycles, before completion.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  store request; held by the requester until `ready`.
- rd_en  in  1  load request; held by the requester until `ready`.
- address  in  32  byte address of the access.
- write_data  in  32  store data.
- read_data  out  32  load result.
- ready  out  1  high means no access is pending, or the current access completes this cycle.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_UB_N  out  1  high-byte mask, active low.
- SRAM_LB_N  out  1  low-byte mask, active low.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_CE_N  out  1  chip enable, active low.
- SRAM_OE_N  out  1  output enable, active low.

Behaviour:
- States: IDLE, LOW, HIGH, WAIT, DONE.
- Reset (async, rst=0):
  - state=IDLE; read_data=0; internal wait counter=0; op/addr/data latches=0.
  - SRAM_WE_N=1 and SRAM_DQ high-Z immediately, even mid-access. An in-flight access is abandoned.
- SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N are tied 0 (always selected, both bytes).
- Index: idx = (address - BASE_ADDR) >> 2, truncated to 17 bits, so out-of-range addresses wrap. Low half uses SRAM_ADDR = {idx,0}; high half uses {idx,1}.
- IDLE:
  - ready = ~(wr_en | rd_en).
  - On a clock edge with a request, latch op, idx and write_data, then go to LOW.
  - wr_en and rd_en both high: treat as a write.
- LOW:
  - SRAM_ADDR = {idx,0}.
  - Write: SRAM_WE_N=0 and SRAM_DQ = wdata[15:0].
  - Read: SRAM_WE_N=1 and SRAM_DQ high-Z; read_data[15:0] captured from SRAM_DQ at the ending edge.
  - Next state: HIGH.
- HIGH:
  - Same as LOW with {idx,1} and bits [31:16].
  - Next state: WAIT if WAIT_CYCLES>0, else DONE.
- WAIT:
  - SRAM_WE_N=1, DQ high-Z, SRAM_ADDR holds {idx,1}.
  - Counter runs 0..WAIT_CYCLES-1, then DONE.
- DONE:
  - ready=1 for exactly one cycle; WE_N=1; DQ high-Z.
  - Next state: IDLE unconditionally.
  - A request still high in the following IDLE cycle is a new access.
- Outside LOW/HIGH: SRAM_WE_N=1 and SRAM_DQ high-Z.
- ready is 0 in LOW, HIGH and WAIT.
- Latency: with a request in cycle 0, LOW is cycle 1, HIGH is cycle 2, and DONE is cycle 3+WAIT_CYCLES (cycle 5 at the default). The access takes 4+WAIT_CYCLES cycles including the request cycle.
- Inputs changing or dropping after the latch edge are ignored; the access always runs to DONE.
- read_data:
  - Read: both halves are updated. The value is stable from the first cycle of WAIT (or of DONE when WAIT_CYCLES=0) until the next read captures.
  - Write: leaves read_data unchanged.
- Write data is driven on SRAM_DQ only while SRAM_WE_N=0. The controller and the SRAM never drive the bus simultaneously.

Test Plan:
- Reset mid-write: assert rst=0 while in LOW -> SRAM_WE_N=1 and SRAM_DQ=Z asynchronously. After release: state IDLE, ready=1 with no request, read_data=0.
- Write: wr_en=1, address=1024, write_data=0xDEADBEEF -> SRAM_ADDR=0 with DQ=0xBEEF and WE_N=0 in cycle 1; SRAM_ADDR=1 with DQ=0xDEAD and WE_N=0 in cycle 2; ready=0 in cycles 0-4, ready=1 in cycle 5.
- Read-back: after the write, rd_en=1, address=1024 -> read_data=0xDEADBEEF when ready rises in cycle 5. Write 0x12345678 at 1028, then read 1028 -> 0x12345678 with SRAM_ADDR 2 and 3.
- Back-to-back: rd_en held high across two accesses -> DONE for one cycle, IDLE with ready=0 one cycle, new LOW next. Exactly 6 cycles between the two ready pulses.
- Both wr_en and rd_en high, address 1032, data 0x0000A5A5 -> performed as a write. A subsequent read of 1032 returns 0x0000A5A5. read_data keeps its prior value during the write.
- Request dropped mid-access: rd_en deasserted in cycle 2 -> access still completes, with ready=1 in cycle 5, then IDLE.
